// File: rtl/eim_rx_stream_if.sv
// EIM bus beat signals plus the incoming sample stream for eim_rx_stream.
// slave is the block's own view; master is the EIM front end / sample source view.
interface eim_rx_stream_if;
  logic        bus_sel;
  logic        bus_wr;
  logic [18:0] bus_addr;
  logic [15:0] bus_data_wr;
  logic [15:0] bus_data_rd;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport slave (
    input  bus_sel, bus_wr, bus_addr, bus_data_wr, in_data, in_valid,
    output bus_data_rd, in_ready
  );

  modport master (
    output bus_sel, bus_wr, bus_addr, bus_data_wr, in_data, in_valid,
    input  bus_data_rd, in_ready
  );
endinterface

// File: rtl/eim_rx_stream.sv
// EIM slave buffering a 16-bit sample stream in a FIFO, read out through a burst DATA window.
// Optional overflow/underflow counters are built when EIM_RX_STREAM_ERRCNT_EN is defined.
module eim_rx_stream #(
  parameter logic [2:0] BASE_SEL   = 3'd1,
  parameter int         DEPTH_LOG2 = 10
) (
  input  logic           bus_clk,
  input  logic           bus_rst_n,
  eim_rx_stream_if.slave bus
);
  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam int                    LW        = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]         LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0]         LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [15:0]           OFF_CTRL  = 16'h0000;
  localparam logic [15:0]           OFF_LEVEL = 16'h0002;
  localparam logic [15:0]           OFF_OVF   = 16'h0004;
  localparam logic [15:0]           OFF_UNF   = 16'h0006;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [LW-1:0]         level_r, level_nxt_s;
  logic                  en_r, en_nxt_s;
  logic [15:0]           rd_data_r, rd_data_nxt_s;
  logic [15:0]           ovf_rd_s, unf_rd_s;

  logic        hit_s, rd_hit_s, wr_hit_s, data_win_s;
  logic [15:0] off_s;
  logic        ctrl_wr_s, flush_s;
  logic        empty_s, full_s;
  logic        pop_req_s, pop_s, push_att_s, push_s;
  logic        ovf_evt_s, unf_evt_s;
  logic        unused_wr_bits_s;

  assign hit_s      = bus.bus_sel && (bus.bus_addr[18:16] == BASE_SEL);
  assign off_s      = bus.bus_addr[15:0];
  assign rd_hit_s   = hit_s && !bus.bus_wr;
  assign wr_hit_s   = hit_s && bus.bus_wr;
  assign data_win_s = (off_s[15:12] == 4'h1);

  assign ctrl_wr_s  = wr_hit_s && (off_s == OFF_CTRL);
  assign flush_s    = ctrl_wr_s && bus.bus_data_wr[1];

  // Level never exceeds DEPTH, so its top bit alone marks the full state.
  assign empty_s    = (level_r == LVL_ZERO);
  assign full_s     = level_r[DEPTH_LOG2];

  assign pop_req_s  = rd_hit_s && data_win_s;
  assign pop_s      = pop_req_s && !empty_s;
  assign push_att_s = bus.in_valid && en_r && !flush_s;
  // A pop in the same cycle frees the slot, so a push at full is still stored.
  assign push_s     = push_att_s && (!full_s || pop_s);
  assign ovf_evt_s  = push_att_s && full_s && !pop_s;
  assign unf_evt_s  = pop_req_s && empty_s;

  assign bus.in_ready    = en_r;
  assign bus.bus_data_rd = rd_data_r;

  assign unused_wr_bits_s = ^bus.bus_data_wr[15:2];

  // Next-state for enable, level and pointers.
  always_comb begin
    en_nxt_s     = en_r;
    level_nxt_s  = level_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (ctrl_wr_s) begin
      en_nxt_s = bus.bus_data_wr[0];
    end else begin
      en_nxt_s = en_r;
    end
    if (flush_s) begin
      level_nxt_s  = LVL_ZERO;
      rd_ptr_nxt_s = wr_ptr_r;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_nxt_s = level_r + LVL_ONE;
        2'b01:   level_nxt_s = level_r - LVL_ONE;
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Read-data mux; values reflect state before this cycle's push/pop.
  always_comb begin
    rd_data_nxt_s = rd_data_r;
    if (rd_hit_s) begin
      if (data_win_s) begin
        if (empty_s) begin
          rd_data_nxt_s = 16'h0000;
        end else begin
          rd_data_nxt_s = mem_r[rd_ptr_r];
        end
      end else begin
        case (off_s)
          OFF_CTRL:  rd_data_nxt_s = {15'h0000, en_r};
          OFF_LEVEL: rd_data_nxt_s = 16'(level_r);
          OFF_OVF:   rd_data_nxt_s = ovf_rd_s;
          OFF_UNF:   rd_data_nxt_s = unf_rd_s;
          default:   rd_data_nxt_s = 16'h0000;
        endcase
      end
    end else begin
      rd_data_nxt_s = rd_data_r;
    end
  end

  // Control/status registers with synchronous active-low reset.
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      en_r      <= 1'b0;
      level_r   <= LVL_ZERO;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      rd_data_r <= 16'h0000;
    end else begin
      en_r      <= en_nxt_s;
      level_r   <= level_nxt_s;
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      rd_data_r <= rd_data_nxt_s;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge bus_clk) begin
    if (bus_rst_n && push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

`ifdef EIM_RX_STREAM_ERRCNT_EN
  logic [15:0] ovf_cnt_r, unf_cnt_r;

  // Saturating drop/underflow counters, cleared only by reset.
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      ovf_cnt_r <= 16'h0000;
      unf_cnt_r <= 16'h0000;
    end else begin
      if (ovf_evt_s) begin
        ovf_cnt_r <= sat_inc(ovf_cnt_r);
      end
      if (unf_evt_s) begin
        unf_cnt_r <= sat_inc(unf_cnt_r);
      end
    end
  end

  assign ovf_rd_s = ovf_cnt_r;
  assign unf_rd_s = unf_cnt_r;
`else
  logic unused_evt_s;

  assign ovf_rd_s     = 16'h0000;
  assign unf_rd_s     = 16'h0000;
  assign unused_evt_s = ovf_evt_s ^ unf_evt_s ^ (sat_inc(16'h0000) == 16'h0000);
`endif

endmodule

// File: tb/tb_eim_rx_stream.sv
// Directed test-plan steps followed by random traffic, checked every cycle against a queue model.
module tb_eim_rx_stream;
  localparam logic [2:0] BASE_SEL   = 3'd1;
  localparam int         DEPTH_LOG2 = 2;
  localparam int         DEPTH      = 4;
`ifdef EIM_RX_STREAM_ERRCNT_EN
  localparam bit         ERRCNT     = 1'b1;
`else
  localparam bit         ERRCNT     = 1'b0;
`endif

  logic bus_clk = 1'b0;
  logic bus_rst_n;

  eim_rx_stream_if bus ();

  eim_rx_stream #(.BASE_SEL(BASE_SEL), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .bus_clk  (bus_clk),
    .bus_rst_n(bus_rst_n),
    .bus      (bus)
  );

  always #5 bus_clk = ~bus_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [15:0] q_m[$];
  bit          en_m  = 1'b0;
  int          ovf_m = 0;
  int          unf_m = 0;
  logic [15:0] rd_m  = 16'h0000;

  function automatic logic [18:0] a(input logic [15:0] off);
    a = {BASE_SEL, off};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: apply one cycle's inputs to the queue model.
  task automatic model_step();
    bit          hit;
    bit          en_old;
    bit          flush;
    logic [15:0] off;
    if (!bus_rst_n) begin
      q_m.delete();
      en_m  = 1'b0;
      ovf_m = 0;
      unf_m = 0;
      rd_m  = 16'h0000;
      return;
    end
    hit    = bus.bus_sel && (bus.bus_addr[18:16] == BASE_SEL);
    off    = bus.bus_addr[15:0];
    en_old = en_m;
    flush  = 1'b0;
    if (hit && !bus.bus_wr) begin
      if (off >= 16'h1000 && off <= 16'h1FFF) begin
        if (q_m.size() > 0) rd_m = q_m.pop_front();
        else begin
          rd_m = 16'h0000;
          if (unf_m < 65535) unf_m++;
        end
      end
      else if (off == 16'h0000) rd_m = {15'h0000, en_m};
      else if (off == 16'h0002) rd_m = 16'(q_m.size());
      else if (off == 16'h0004) rd_m = ERRCNT ? 16'(ovf_m) : 16'h0000;
      else if (off == 16'h0006) rd_m = ERRCNT ? 16'(unf_m) : 16'h0000;
      else rd_m = 16'h0000;
    end
    if (hit && bus.bus_wr && off == 16'h0000) begin
      en_m = bus.bus_data_wr[0];
      if (bus.bus_data_wr[1]) begin
        flush = 1'b1;
        q_m.delete();
      end
    end
    if (en_old && bus.in_valid && !flush) begin
      if (q_m.size() < DEPTH) q_m.push_back(bus.in_data);
      else if (ovf_m < 65535) ovf_m++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge bus_clk);
    #1;
    check("rd_data", bus.bus_data_rd, rd_m);
    check("in_ready", {15'h0000, bus.in_ready}, {15'h0000, en_m});
  endtask

  task automatic beat(input logic wr, input logic [18:0] addr, input logic [15:0] data);
    bus.bus_sel     = 1'b1;
    bus.bus_wr      = wr;
    bus.bus_addr    = addr;
    bus.bus_data_wr = data;
    tick();
    bus.bus_sel     = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [15:0] off, input logic [15:0] exp);
    beat(1'b0, a(off), 16'h0000);
    check(tag, bus.bus_data_rd, exp);
  endtask

  task automatic push(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int          kind;
    logic [15:0] roff;
    logic [15:0] reg_offs[7];
    reg_offs = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0FFE, 16'h2000};

    bus_rst_n       = 1'b0;
    bus.bus_sel     = 1'b0;
    bus.bus_wr      = 1'b0;
    bus.bus_addr    = 19'h00000;
    bus.bus_data_wr = 16'h0000;
    bus.in_valid    = 1'b0;
    bus.in_data     = 16'h0000;

    // Reset
    tick();
    check("rst_rd_data", bus.bus_data_rd, 16'h0000);
    check("rst_in_ready", {15'h0000, bus.in_ready}, 16'h0000);
    bus_rst_n = 1'b1;
    rd_expect("rst_ctrl", 16'h0000, 16'h0000);
    rd_expect("rst_level", 16'h0002, 16'h0000);

    // Fill and burst
    beat(1'b1, a(16'h0000), 16'h0001);
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    rd_expect("fill_level", 16'h0002, 16'h0004);
    rd_expect("burst0", 16'h1000, 16'h1111);
    rd_expect("burst1", 16'h1002, 16'h2222);
    rd_expect("burst2", 16'h1004, 16'h3333);
    rd_expect("burst3", 16'h1006, 16'h4444);
    rd_expect("burst_level", 16'h0002, 16'h0000);

    // Non-hit beat holds the read data
    bus.bus_sel = 1'b1; bus.bus_wr = 1'b0; bus.bus_addr = {3'd2, 16'h0002};
    tick();
    bus.bus_sel = 1'b0;
    check("nonhit_hold", bus.bus_data_rd, 16'h0000);

    // Overflow
    for (int i = 1; i <= 6; i++) push(16'hA000 + 16'(i));
    rd_expect("ovf_level", 16'h0002, 16'h0004);
    rd_expect("ovf_cnt", 16'h0004, ERRCNT ? 16'h0002 : 16'h0000);
    for (int i = 1; i <= 4; i++) rd_expect("ovf_data", 16'h1000 + 16'(2 * i), 16'hA000 + 16'(i));

    // Underflow
    for (int i = 0; i < 3; i++) rd_expect("unf_data", 16'h1FFE, 16'h0000);
    rd_expect("unf_cnt", 16'h0006, ERRCNT ? 16'h0003 : 16'h0000);
    rd_expect("unf_level", 16'h0002, 16'h0000);

    // Underflow with a simultaneous push still stores the sample
    bus.in_valid = 1'b1; bus.in_data = 16'hE001;
    rd_expect("unf_push_data", 16'h1000, 16'h0000);
    bus.in_valid = 1'b0;
    rd_expect("unf_push_level", 16'h0002, 16'h0001);
    rd_expect("unf_push_pop", 16'h1000, 16'hE001);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push(16'hB000 + 16'(i));
    bus.in_valid = 1'b1; bus.in_data = 16'hAAAA;
    rd_expect("full_pp_data", 16'h1000, 16'hB001);
    bus.in_valid = 1'b0;
    rd_expect("full_pp_ovf", 16'h0004, ERRCNT ? 16'h0002 : 16'h0000);
    rd_expect("full_pp_level", 16'h0002, 16'h0004);
    rd_expect("full_pp_d1", 16'h1000, 16'hB002);
    rd_expect("full_pp_d2", 16'h1000, 16'hB003);
    rd_expect("full_pp_d3", 16'h1000, 16'hB004);
    rd_expect("full_pp_last", 16'h1000, 16'hAAAA);

    // Flush with a same-cycle sample
    push(16'hC001); push(16'hC002); push(16'hC003);
    rd_expect("flush_pre_level", 16'h0002, 16'h0003);
    bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    beat(1'b1, a(16'h0000), 16'h0003);
    bus.in_valid = 1'b0;
    rd_expect("flush_level", 16'h0002, 16'h0000);
    rd_expect("flush_ctrl", 16'h0000, 16'h0001);
    push(16'hD001); push(16'hD002);
    rd_expect("flush_post_level", 16'h0002, 16'h0002);
    rd_expect("flush_post_d0", 16'h1000, 16'hD001);
    rd_expect("flush_post_d1", 16'h1000, 16'hD002);

    // EN=0 blocks pushes but pops still drain
    push(16'hF001); push(16'hF002);
    beat(1'b1, a(16'h0000), 16'h0000);
    push(16'hF003);
    rd_expect("dis_d0", 16'h1000, 16'hF001);
    rd_expect("dis_d1", 16'h1000, 16'hF002);
    rd_expect("dis_level", 16'h0002, 16'h0000);

    // Reset mid-burst discards contents
    beat(1'b1, a(16'h0000), 16'h0001);
    push(16'h5001); push(16'h5002);
    rd_expect("mid_d0", 16'h1000, 16'h5001);
    bus_rst_n = 1'b0;
    beat(1'b0, a(16'h1002), 16'h0000);
    bus_rst_n = 1'b1;
    rd_expect("mid_level", 16'h0002, 16'h0000);
    rd_expect("mid_ctrl", 16'h0000, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus_rst_n    = ($urandom_range(0, 199) != 0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 16'($urandom);
      kind         = $urandom_range(0, 9);
      bus.bus_sel  = (kind != 9);
      bus.bus_wr   = 1'b0;
      bus.bus_data_wr = 16'($urandom);
      if (kind <= 4) begin
        roff = {4'h1, 11'($urandom), 1'b0};
        bus.bus_addr = a(roff);
      end else if (kind == 5) begin
        bus.bus_addr = a(reg_offs[$urandom_range(0, 6)]);
      end else if (kind == 6) begin
        bus.bus_wr = 1'b1;
        bus.bus_addr = a(16'h0000);
        bus.bus_data_wr[1] = ($urandom_range(0, 3) == 0);
        bus.bus_data_wr[0] = ($urandom_range(0, 3) != 0);
      end else if (kind == 7) begin
        bus.bus_wr = 1'b1;
        bus.bus_addr = a(reg_offs[$urandom_range(1, 6)]);
      end else begin
        bus.bus_wr = 1'($urandom_range(0, 1));
        bus.bus_addr = {3'($urandom_range(2, 7)), 16'h0000};
      end
      tick();
    end
    bus_rst_n   = 1'b1;
    bus.bus_sel = 1'b0;
    bus.in_valid = 1'b0;
    rd_expect("final_level", 16'h0002, 16'(q_m.size()));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
